// File: rtl/rt_mem_loader.sv
// rt_mem_loader: boot-time loader packing a byte stream into words and writing them through dp_ram port B.
// Define RT_LOADER_VERIFY_EN to read back and compare every written word.
module rt_mem_loader #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 22,
   parameter int                    NUM_WORDS      = 4137,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 256,
   parameter int                    SETTLE_CYCLES  = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic                           byte_valid_i,
   input  logic [7:0]                     byte_data_i,
   output logic                           byte_ready_o,
   output logic                           mem_en_o,
   output logic                           mem_we_o,
   output logic [ADDR_WIDTH-1:0]          mem_addr_o,
   output logic [DATA_WIDTH-1:0]          mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]        mem_be_o,
   output logic                           mem_lim_inhibit_o,
   input  logic                           mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]          mem_rdata_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic                           fetch_enable_o,
   output logic [$clog2(NUM_WORDS+1)-1:0] words_done_o
);
   localparam int LANES = DATA_WIDTH / 8;
   localparam int LW    = $clog2(LANES);
   localparam int WW    = $clog2(NUM_WORDS + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW    = $clog2(SETTLE_CYCLES + 2);
   // Settle latency counts from the last rvalid cycle, so NEXT and the first SETTLE cycle are part of it
   localparam int SETTLE_EXTRA = SETTLE_CYCLES > 3 ? SETTLE_CYCLES - 3 : 0;

   typedef enum logic [3:0] {
      IDLE, GATHER, WRITE, WAIT_W,
`ifdef RT_LOADER_VERIFY_EN
      RD, WAIT_R,
`endif
      NEXT, SETTLE, DONE, ERROR
   } state_t;

   state_t                  state_q, state_d;
   logic [LW-1:0]           lane_q;
   logic [WW-1:0]           words_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [TW-1:0]           tmo_q;
   logic [SW-1:0]           set_q;
   logic                    ready_q, en_q, we_q, busy_q, done_q, err_q;
   logic [LANES-1:0]        be_q;
   logic                    accept, tmo_hit, last, waiting, rd_d;

   assign accept  = ready_q & byte_valid_i;
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign last    = words_q == WW'(NUM_WORDS - 1);

`ifdef RT_LOADER_VERIFY_EN
   assign waiting = state_q == WAIT_W || state_q == WAIT_R;
   assign rd_d    = state_d == RD;
`else
   logic unused_rdata;
   assign unused_rdata = ^mem_rdata_i;
   assign waiting      = state_q == WAIT_W;
   assign rd_d         = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   state_d = start_i ? GATHER : IDLE;
         GATHER: state_d = (accept && lane_q == LW'(LANES - 1)) ? WRITE : GATHER;
         WRITE:  state_d = WAIT_W;
`ifdef RT_LOADER_VERIFY_EN
         WAIT_W: state_d = mem_rvalid_i ? RD : tmo_hit ? ERROR : WAIT_W;
         RD:     state_d = WAIT_R;
         WAIT_R: state_d = mem_rvalid_i ? ((mem_rdata_i == wdata_q) ? NEXT : ERROR)
                                        : tmo_hit ? ERROR : WAIT_R;
`else
         WAIT_W: state_d = mem_rvalid_i ? NEXT : tmo_hit ? ERROR : WAIT_W;
`endif
         NEXT:   state_d = last ? SETTLE : GATHER;
         SETTLE: state_d = (set_q == SW'(SETTLE_EXTRA)) ? DONE : SETTLE;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         lane_q  <= '0;
         words_q <= '0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         tmo_q   <= '0;
         set_q   <= '0;
         ready_q <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= state_d == GATHER;
         en_q    <= state_d == WRITE || rd_d;
         we_q    <= state_d == WRITE;
         be_q    <= {LANES{state_d == WRITE || state_d == WAIT_W}};
         busy_q  <= !(state_d inside {IDLE, DONE, ERROR});
         done_q  <= state_d == DONE;
         err_q   <= state_d == ERROR;
         tmo_q   <= waiting ? tmo_q + 1'b1 : '0;
         set_q   <= state_q == SETTLE ? set_q + 1'b1 : '0;
         if (state_q == IDLE && start_i) begin
            addr_q  <= BASE_ADDR;
            words_q <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
         end
         if (accept) begin
            wdata_q[{lane_q, 3'b000} +: 8] <= byte_data_i;
            lane_q                         <= lane_q == LW'(LANES - 1) ? '0 : lane_q + 1'b1;
         end
         if (state_q == NEXT) begin
            words_q <= words_q + 1'b1;
            addr_q  <= addr_q + ADDR_WIDTH'(LANES);
         end
      end
   end

   assign byte_ready_o      = ready_q;
   assign mem_en_o          = en_q;
   assign mem_we_o          = we_q;
   assign mem_addr_o        = addr_q;
   assign mem_wdata_o       = wdata_q;
   assign mem_be_o          = be_q;
   assign mem_lim_inhibit_o = busy_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;
   assign error_o           = err_q;
   assign fetch_enable_o    = done_q & ~err_q;
   assign words_done_o      = words_q;
endmodule
